// File: rtl/rc_unit_vc.sv
// rc_unit_vc: route computation for one input port of a 2D-mesh router.
// Registered XY dimension-order routing with a per-VC route table. A VC's
// output port is held from head acceptance until the buffer releases it.
// Optional build macro: RC_BOUNDARY_CHECK_EN (out-of-mesh destinations are
// ejected locally via CENTER and flagged on dest_err_o).

package rc_unit_vc_pkg;
  typedef enum logic [2:0] {
    CENTER = 3'd0,
    LEFT   = 3'd1,
    RIGHT  = 3'd2,
    UP     = 3'd3,
    DOWN   = 3'd4
  } port_t;
endpackage

// state  | meaning
// IDLE   | no route held; VC accepts a head flit
// ROUTED | route held in out_port_o[i] until release_i[i]
module rc_unit_vc
  import rc_unit_vc_pkg::*;
#(
  parameter int MESH_SIZE_X      = 4,
  parameter int MESH_SIZE_Y      = 4,
  parameter int X_CURRENT        = 0,
  parameter int Y_CURRENT        = 0,
  parameter int VC_NUM           = 2,
  parameter int DEST_ADDR_SIZE_X = (MESH_SIZE_X > 1) ? $clog2(MESH_SIZE_X) : 1,
  parameter int DEST_ADDR_SIZE_Y = (MESH_SIZE_Y > 1) ? $clog2(MESH_SIZE_Y) : 1,
  // derived from VC_NUM; not meant to be overridden
  parameter int VC_IDX_W         = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        head_valid_i,
  input  logic [VC_IDX_W-1:0]         head_vc_i,
  input  logic [DEST_ADDR_SIZE_X-1:0] x_dest_i,
  input  logic [DEST_ADDR_SIZE_Y-1:0] y_dest_i,
  input  logic [VC_NUM-1:0]           release_i,
  output logic [VC_NUM-1:0]           ready_o,
  output logic [VC_NUM-1:0]           route_valid_o,
  output port_t [VC_NUM-1:0]          out_port_o,
  output logic                        proto_err_o
`ifdef RC_BOUNDARY_CHECK_EN
  ,
  output logic                        dest_err_o
`endif
);

  typedef enum logic {
    IDLE   = 1'b0,
    ROUTED = 1'b1
  } vc_state_t;

  // Compares are done in a 32-bit unsigned domain so that narrow address
  // fields and parameter limits never get truncated against each other.
  localparam logic [31:0] X_CUR  = 32'(X_CURRENT);
  localparam logic [31:0] Y_CUR  = 32'(Y_CURRENT);
  localparam logic [31:0] VC_LIM = 32'(VC_NUM);

  vc_state_t           r_state [VC_NUM];
  port_t [VC_NUM-1:0]  r_out_port;
  logic                r_proto_err;

  logic [31:0]         w_x_ext;
  logic [31:0]         w_y_ext;
  logic [31:0]         w_vc_ext;
  logic                w_vc_ok;
  port_t               w_route;
  logic [VC_NUM-1:0]   w_idle;
  logic [VC_NUM-1:0]   w_hit;
  logic [VC_NUM-1:0]   w_accept;
  logic                w_err;

  assign w_x_ext  = 32'(x_dest_i);
  assign w_y_ext  = 32'(y_dest_i);
  assign w_vc_ext = 32'(head_vc_i);
  assign w_vc_ok  = (w_vc_ext < VC_LIM);

`ifdef RC_BOUNDARY_CHECK_EN
  logic w_dest_bad;
  logic r_dest_err;
  assign w_dest_bad = (w_x_ext >= 32'(MESH_SIZE_X)) || (w_y_ext >= 32'(MESH_SIZE_Y));
  assign dest_err_o = r_dest_err;
`endif

  // XY dimension-order route of the presented head: resolve X first, then Y
  always_comb begin
    w_route = CENTER;
    if (w_x_ext < X_CUR)      w_route = LEFT;
    else if (w_x_ext > X_CUR) w_route = RIGHT;
    else if (w_y_ext < Y_CUR) w_route = UP;
    else if (w_y_ext > Y_CUR) w_route = DOWN;
`ifdef RC_BOUNDARY_CHECK_EN
    if (w_dest_bad) w_route = CENTER;
`endif
  end

  // Per-VC handshake: readiness, head acceptance and protocol-error detection
  always_comb begin
    w_idle        = '0;
    w_hit         = '0;
    ready_o       = '0;
    route_valid_o = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      w_idle[i]        = (r_state[i] == IDLE);
      ready_o[i]       = w_idle[i] | release_i[i];
      route_valid_o[i] = (r_state[i] == ROUTED);
      w_hit[i]         = head_valid_i && w_vc_ok && (head_vc_i == VC_IDX_W'(i));
    end
    w_accept = w_hit & ready_o;
    // busy VC, VC index out of range, or release of a VC that holds no route
    w_err    = (|(w_hit & ~ready_o)) || (head_valid_i && !w_vc_ok) ||
               (|(release_i & w_idle));
  end

  // VC state machines, held route table and sticky protocol error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < VC_NUM; i++) begin
        r_state[i]    <= IDLE;
        r_out_port[i] <= CENTER;
      end
      r_proto_err <= 1'b0;
    end else begin
      for (int i = 0; i < VC_NUM; i++) begin
        if (w_accept[i]) begin
          // also covers release+head in one cycle: the route is reloaded
          r_state[i]    <= ROUTED;
          r_out_port[i] <= w_route;
        end else if (release_i[i] && (r_state[i] == ROUTED)) begin
          // out_port keeps its last value; only the valid flag drops
          r_state[i] <= IDLE;
        end
      end
      if (w_err) r_proto_err <= 1'b1;
    end
  end

`ifdef RC_BOUNDARY_CHECK_EN
  // Sticky flag for accepted heads addressed outside the mesh
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             r_dest_err <= 1'b0;
    else if ((|w_accept) && w_dest_bad)   r_dest_err <= 1'b1;
  end
`endif

  assign out_port_o  = r_out_port;
  assign proto_err_o = r_proto_err;

endmodule
